mem_write_checker: RTL and testbench

//  Synthesizable, parametrised self-check monitor for the ARM cores (single-cycle now, multi-cycle/pipelined next).

---
 rtl/mem_write_checker_if.sv | 39 +++
 rtl/mem_write_checker.sv | 134 +++++++++++++
 tb/tb_mem_write_checker.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_checker_if.sv
// Bus bundle between a core's data-memory write port, the table loader/controller
// and the store checker.
interface mem_write_checker_if #(
  parameter int DW = 32,
  parameter int IW = 3,
  parameter int TW = 16
) ();
  logic          MemWrite;
  logic [DW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic          ld_en;
  logic [IW-1:0] ld_idx;
  logic [DW-1:0] ld_adr;
  logic [DW-1:0] ld_data;
  logic [IW:0]   exp_cnt;
  logic          ign_en;
  logic [DW-1:0] ign_adr;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [1:0]    fail_code;
  logic [IW:0]   match_cnt;
  logic [TW-1:0] cycle_cnt;
  logic [DW-1:0] fail_adr;
  logic [DW-1:0] fail_data;

  modport master (
    output MemWrite, DataAdr, WriteData, ld_en, ld_idx, ld_adr, ld_data,
           exp_cnt, ign_en, ign_adr, start,
    input  busy, done, pass, fail_code, match_cnt, cycle_cnt, fail_adr, fail_data
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, ld_en, ld_idx, ld_adr, ld_data,
           exp_cnt, ign_en, ign_adr, start,
    output busy, done, pass, fail_code, match_cnt, cycle_cnt, fail_adr, fail_data
  );
endinterface

// File: rtl/mem_write_checker.sv
// Snoops a core's store port and checks the stores, in order, against a loaded
// table of expected (address, data) pairs; reports pass, mismatch or timeout.
module mem_write_checker #(
  parameter int DW      = 32,
  parameter int DEPTH   = 8,
  parameter int IW      = 3,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 16
) (
  input logic               clk,
  input logic               Reset,
  mem_write_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  localparam logic [IW:0]   DEPTH_W       = (IW+1)'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_W     = TW'(TIMEOUT);
  localparam logic [1:0]    CODE_NONE     = 2'b00;
  localparam logic [1:0]    CODE_MISMATCH = 2'b01;
  localparam logic [1:0]    CODE_TIMEOUT  = 2'b10;

  state_t        state_reg, state_next;
  logic [IW:0]   n_reg, n_next;
  logic [IW:0]   match_reg, match_next;
  logic [TW-1:0] cycle_reg, cycle_next;
  logic [1:0]    code_reg, code_next;
  logic [DW-1:0] fail_adr_reg, fail_adr_next;
  logic [DW-1:0] fail_data_reg, fail_data_next;

  logic [DW-1:0] adr_tab  [DEPTH];
  logic [DW-1:0] data_tab [DEPTH];

  logic          ld_we;
  logic          store;
  logic          hit;
  logic [IW-1:0] cur_idx;
  logic [IW:0]   match_inc;

  // The table is cleared by reset, so it lives in registers rather than RAM.
  assign ld_we = (state_reg == IDLE) && bus.ld_en && ({1'b0, bus.ld_idx} < DEPTH_W);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        adr_tab[i]  <= '0;
        data_tab[i] <= '0;
      end
    end else if (ld_we) begin
      adr_tab[bus.ld_idx]  <= bus.ld_adr;
      data_tab[bus.ld_idx] <= bus.ld_data;
    end
  end

  // In RUN match_reg < N <= DEPTH, so the low bits always address a valid entry.
  assign cur_idx   = match_reg[IW-1:0];
  assign hit       = (adr_tab[cur_idx] == bus.DataAdr) && (data_tab[cur_idx] == bus.WriteData);
  assign store     = bus.MemWrite && !(bus.ign_en && (bus.DataAdr == bus.ign_adr));
  assign match_inc = match_reg + 1'b1;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      match_reg     <= '0;
      cycle_reg     <= '0;
      code_reg      <= CODE_NONE;
      fail_adr_reg  <= '0;
      fail_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      n_reg         <= n_next;
      match_reg     <= match_next;
      cycle_reg     <= cycle_next;
      code_reg      <= code_next;
      fail_adr_reg  <= fail_adr_next;
      fail_data_reg <= fail_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    n_next         = n_reg;
    match_next     = match_reg;
    cycle_next     = cycle_reg;
    code_next      = code_reg;
    fail_adr_next  = fail_adr_reg;
    fail_data_next = fail_data_reg;
    case (state_reg)
      RUN: begin
        cycle_next = cycle_reg + 1'b1;
        if (store) begin
          if ((n_reg != '0) && hit) begin
            match_next = match_inc;
            if (match_inc == n_reg) state_next = PASS;
          end else begin
            state_next     = FAIL;
            code_next      = CODE_MISMATCH;
            fail_adr_next  = bus.DataAdr;
            fail_data_next = bus.WriteData;
          end
        end else if (n_reg == '0) begin
          state_next = PASS;
        end
        // Timeout loses to any verdict reached on the same edge.
        if ((state_next == RUN) && (cycle_next == TIMEOUT_W)) begin
          state_next     = FAIL;
          code_next      = CODE_TIMEOUT;
          fail_adr_next  = '0;
          fail_data_next = '0;
        end
      end
      default: begin
        if (bus.start) begin
          state_next     = RUN;
          n_next         = (bus.exp_cnt > DEPTH_W) ? DEPTH_W : bus.exp_cnt;
          match_next     = '0;
          cycle_next     = '0;
          code_next      = CODE_NONE;
          fail_adr_next  = '0;
          fail_data_next = '0;
        end
      end
    endcase
  end

  assign bus.busy      = (state_reg == RUN);
  assign bus.done      = (state_reg == PASS) || (state_reg == FAIL);
  assign bus.pass      = (state_reg == PASS);
  assign bus.fail_code = code_reg;
  assign bus.match_cnt = match_reg;
  assign bus.cycle_cnt = cycle_reg;
  assign bus.fail_adr  = fail_adr_reg;
  assign bus.fail_data = fail_data_reg;
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: a store-level reference model is compared
// against the outputs every cycle, plus hand-computed literal expectations.
module tb_mem_write_checker;
  localparam int DW = 32, DEPTH = 8, IW = 3, TIMEOUT = 20, TW = 16;

  logic clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  mem_write_checker_if #(.DW(DW), .IW(IW), .TW(TW)) bif ();

  mem_write_checker #(.DW(DW), .DEPTH(DEPTH), .IW(IW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 passed, 3 failed.
  int          m_phase = 0, m_n = 0, m_match = 0, m_cyc = 0, m_code = 0;
  logic [31:0] m_fadr = '0, m_fdata = '0;
  logic [31:0] m_tadr [DEPTH];
  logic [31:0] m_tdata [DEPTH];

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_match = 0; m_cyc = 0; m_code = 0;
    m_fadr = '0; m_fdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_tadr[i] = '0;
      m_tdata[i] = '0;
    end
  endtask

  task automatic model_step();
    bit counted;
    if (m_phase != 1) begin
      if (m_phase == 0 && bif.ld_en && int'(bif.ld_idx) < DEPTH) begin
        m_tadr[int'(bif.ld_idx)]  = bif.ld_adr;
        m_tdata[int'(bif.ld_idx)] = bif.ld_data;
      end
      if (bif.start) begin
        m_phase = 1; m_match = 0; m_cyc = 0; m_code = 0; m_fadr = '0; m_fdata = '0;
        m_n = (int'(bif.exp_cnt) > DEPTH) ? DEPTH : int'(bif.exp_cnt);
      end
    end else begin
      m_cyc++;
      counted = bif.MemWrite && !(bif.ign_en && bif.DataAdr == bif.ign_adr);
      if (counted) begin
        if (m_match < m_n && bif.DataAdr == m_tadr[m_match] && bif.WriteData == m_tdata[m_match]) begin
          m_match++;
          if (m_match == m_n) m_phase = 2;
        end else begin
          m_phase = 3; m_code = 1; m_fadr = bif.DataAdr; m_fdata = bif.WriteData;
        end
      end else if (m_n == 0) begin
        m_phase = 2;
      end
      if (m_phase == 1 && m_cyc == TIMEOUT) begin
        m_phase = 3; m_code = 2;
      end
    end
  endtask

  always @(posedge clk or negedge Reset) begin
    if (!Reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    check("busy",      64'(bif.busy),      64'(m_phase == 1));
    check("done",      64'(bif.done),      64'(m_phase >= 2));
    check("pass",      64'(bif.pass),      64'(m_phase == 2));
    check("fail_code", 64'(bif.fail_code), 64'(m_code));
    check("match_cnt", 64'(bif.match_cnt), 64'(m_match));
    check("cycle_cnt", 64'(bif.cycle_cnt), 64'(m_cyc));
    check("fail_adr",  64'(bif.fail_adr),  64'(m_fadr));
    check("fail_data", 64'(bif.fail_data), 64'(m_fdata));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic load(input int idx, input logic [31:0] adr, input logic [31:0] data);
    bif.ld_en = 1'b1; bif.ld_idx = IW'(idx); bif.ld_adr = adr; bif.ld_data = data;
    step();
    bif.ld_en = 1'b0;
  endtask

  task automatic start_run(input int cnt);
    bif.exp_cnt = (IW+1)'(cnt); bif.start = 1'b1;
    step();
    bif.start = 1'b0;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    bif.MemWrite = 1'b1; bif.DataAdr = adr; bif.WriteData = data;
    step();
    bif.MemWrite = 1'b0;
    $display("store adr=%0d data=%0d -> busy=%0b pass=%0b code=%0d match=%0d cyc=%0d",
             adr, data, bif.busy, bif.pass, bif.fail_code, bif.match_cnt, bif.cycle_cnt);
  endtask

  function automatic logic [31:0] e_adr(input int i);
    return 32'(200 + 4 * i);
  endfunction

  function automatic logic [31:0] e_dat(input int i);
    return 32'(3 * i + 1);
  endfunction

  initial begin
    Reset = 1'b0;
    bif.MemWrite = 1'b0; bif.DataAdr = '0; bif.WriteData = '0;
    bif.ld_en = 1'b0; bif.ld_idx = '0; bif.ld_adr = '0; bif.ld_data = '0;
    bif.exp_cnt = '0; bif.ign_en = 1'b0; bif.ign_adr = '0; bif.start = 1'b0;
    #12 Reset = 1'b1;
    check("rst_busy", 64'(bif.busy), 64'd0);
    check("rst_done", 64'(bif.done), 64'd0);
    check("rst_match", 64'(bif.match_cnt), 64'd0);

    // Single expected store with an ignored scratch store ahead of it.
    bif.ign_en = 1'b1; bif.ign_adr = 32'd96;
    load(0, 32'd100, 32'd7);
    start_run(1);
    store(32'd96, 32'hdead_beef);
    store(32'd100, 32'd7);
    check("t1_pass", 64'(bif.pass), 64'd1);
    check("t1_match", 64'(bif.match_cnt), 64'd1);
    check("t1_code", 64'(bif.fail_code), 64'd0);

    // Re-arm from PASS clears counters; wrong data is a mismatch.
    start_run(1);
    check("t2_busy", 64'(bif.busy), 64'd1);
    check("t2_match_clr", 64'(bif.match_cnt), 64'd0);
    check("t2_cyc_clr", 64'(bif.cycle_cnt), 64'd0);
    store(32'd96, 32'd3);
    store(32'd100, 32'd8);
    check("t2_code", 64'(bif.fail_code), 64'd1);
    check("t2_fadr", 64'(bif.fail_adr), 64'd100);
    check("t2_fdata", 64'(bif.fail_data), 64'd8);
    check("t2_done", 64'(bif.done), 64'd1);
    check("t2_pass", 64'(bif.pass), 64'd0);

    // Timeout lands exactly TIMEOUT edges after the start edge.
    start_run(1);
    idle(TIMEOUT - 1);
    check("t3_busy_19", 64'(bif.busy), 64'd1);
    idle(1);
    check("t3_code", 64'(bif.fail_code), 64'd2);
    check("t3_cyc", 64'(bif.cycle_cnt), 64'd20);
    check("t3_fadr", 64'(bif.fail_adr), 64'd0);

    // Full table, in order; then clamped exp_cnt; then out-of-order store.
    @(posedge clk); #2 Reset = 1'b0;
    @(posedge clk); #1 Reset = 1'b1;
    bif.ign_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) load(i, e_adr(i), e_dat(i));
    start_run(8);
    for (int i = 0; i < DEPTH; i++) store(e_adr(i), e_dat(i));
    check("t4_pass", 64'(bif.pass), 64'd1);
    check("t4_match", 64'(bif.match_cnt), 64'd8);
    check("t4_cyc", 64'(bif.cycle_cnt), 64'd8);
    start_run(15);
    for (int i = 0; i < DEPTH; i++) store(e_adr(i), e_dat(i));
    check("t4_clamp_pass", 64'(bif.pass), 64'd1);
    start_run(8);
    store(e_adr(0), e_dat(0)); store(e_adr(1), e_dat(1)); store(e_adr(2), e_dat(2));
    store(e_adr(4), e_dat(4));
    check("t4_swap_code", 64'(bif.fail_code), 64'd1);
    check("t4_swap_match", 64'(bif.match_cnt), 64'd3);
    check("t4_swap_fadr", 64'(bif.fail_adr), 64'd216);
    check("t4_swap_fdata", 64'(bif.fail_data), 64'd13);

    // Same-edge priorities against timeout.
    start_run(1);
    idle(TIMEOUT - 1);
    store(e_adr(0), e_dat(0));
    check("t5_pass", 64'(bif.pass), 64'd1);
    check("t5_cyc", 64'(bif.cycle_cnt), 64'd20);
    start_run(1);
    idle(TIMEOUT - 1);
    store(32'd999, 32'd1);
    check("t5_mis_code", 64'(bif.fail_code), 64'd1);
    start_run(2);
    idle(TIMEOUT - 1);
    store(e_adr(0), e_dat(0));
    check("t5_to_code", 64'(bif.fail_code), 64'd2);
    check("t5_to_match", 64'(bif.match_cnt), 64'd1);

    // N = 0: one RUN cycle, ignored stores allowed, real stores fail.
    start_run(0);
    check("n0_busy", 64'(bif.busy), 64'd1);
    idle(1);
    check("n0_pass", 64'(bif.pass), 64'd1);
    check("n0_cyc", 64'(bif.cycle_cnt), 64'd1);
    bif.ign_en = 1'b1; bif.ign_adr = 32'd96;
    start_run(0);
    store(32'd96, 32'd1);
    check("n0_ign_pass", 64'(bif.pass), 64'd1);
    start_run(0);
    store(32'd300, 32'd1);
    check("n0_st_code", 64'(bif.fail_code), 64'd1);
    check("n0_st_fadr", 64'(bif.fail_adr), 64'd300);

    // Loads during RUN are dropped; async reset mid-RUN; table cleared by reset.
    bif.ign_en = 1'b0;
    start_run(8);
    store(e_adr(0), e_dat(0)); store(e_adr(1), e_dat(1));
    load(2, 32'd0, 32'd0);
    store(e_adr(2), e_dat(2));
    check("t6_match", 64'(bif.match_cnt), 64'd3);
    check("t6_busy", 64'(bif.busy), 64'd1);
    #2 Reset = 1'b0;
    #1;
    check("t6_rst_busy", 64'(bif.busy), 64'd0);
    check("t6_rst_match", 64'(bif.match_cnt), 64'd0);
    check("t6_rst_cyc", 64'(bif.cycle_cnt), 64'd0);
    @(posedge clk); #1 Reset = 1'b1;
    start_run(1);
    store(32'd0, 32'd0);
    check("t6_clr_pass", 64'(bif.pass), 64'd1);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
